// File: rtl/tagger_word_decoder.sv
// -----------------------------------------------------------------------------
// tagger_word_decoder
//
// Host-side / loopback decoder for the 32-bit tagger word stream produced by
// the tag serializer. Words are popped from a standard (non-FWFT) FIFO, one
// word every three clocks. Keepalive NOPs are dropped and counter rollovers
// are folded into an epoch register. Each tag word becomes one absolute
// timestamp {epoch, counter, subtime} on a valid/ready output.
//
// Word format:
//   [31] rollover  [30] overflow  [29] tag  [28] reserved (0)
//   [27:24] channel  [23:16] subtime  [15:0] counter
//
// Parameters:
//   CHANNELS       number of valid channels (1..16); higher channels are dropped
//   SUBTIME_BITS   significant subtime bits (1..8), taken from word[16 +: SUBTIME_BITS]
//   ROLLOVER_BITS  width of the epoch (rollover) counter
//
// Ports:
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   clear        sync pulse: clears epoch, out_overflow, out_error (and stats)
//   read_empty   FIFO empty flag
//   read_enable  registered FIFO pop; read_data is valid the cycle after
//   read_data    FIFO word
//   out_valid    timestamp available
//   out_ready    consumer accepts on a clk edge with out_valid & out_ready
//   out_channel  tag channel
//   out_time     {epoch, counter, subtime}
//   out_overflow sticky: an overflow word was seen
//   out_error    sticky: malformed word or out-of-range channel
//
// Optional feature (macro TAGGER_DECODER_STATS_EN):
//   nop_count    saturating count of NOP words decoded
//   tag_count    saturating count of emitted tags
// -----------------------------------------------------------------------------
module tagger_word_decoder #(
  parameter int CHANNELS      = 1,
  parameter int SUBTIME_BITS  = 8,
  parameter int ROLLOVER_BITS = 24
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      read_empty,
  output logic                                      read_enable,
  input  logic [31:0]                               read_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [3:0]                                out_channel,
  output logic [ROLLOVER_BITS+16+SUBTIME_BITS-1:0]  out_time,
  output logic                                      out_overflow,
  output logic                                      out_error
`ifdef TAGGER_DECODER_STATS_EN
  ,
  output logic [31:0]                               nop_count,
  output logic [31:0]                               tag_count
`endif
);

  localparam logic [4:0] CHAN_LIMIT = 5'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t                   state;
  logic [ROLLOVER_BITS-1:0] epoch;

  // Word classification, only meaningful while state == S_DECODE.
  logic is_tag;
  logic chan_ok;
  logic is_nop;
  logic tag_flags;    // rollover/overflow bits set inside a tag word
  logic nontag_junk;  // reserved/payload bits set inside a non-tag word
  logic decode_now;
  logic emit_tag;

  // NOTE: every signal driven here gets a value on every path first, so no
  // latch is inferred when a branch does not assign it.
  always_comb begin
    is_tag      = read_data[29];
    chan_ok     = {1'b0, read_data[27:24]} < CHAN_LIMIT;
    is_nop      = (read_data == 32'd0);
    tag_flags   = |read_data[31:30];
    nontag_junk = |read_data[28:0];
    decode_now  = (state == S_DECODE);
    emit_tag    = decode_now && is_tag && chan_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block (clear) override
  // earlier ones, which gives clear priority over a coincident decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      read_enable  <= 1'b0;
      out_valid    <= 1'b0;
      out_channel  <= 4'd0;
      out_time     <= '0;
      out_overflow <= 1'b0;
      out_error    <= 1'b0;
      epoch        <= '0;
    end else begin
      // Acceptance frees the output register; a decode below may refill it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // Only pop when the output register will be free by decode time.
          if (!read_empty && (!out_valid || out_ready)) begin
            read_enable <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          read_enable <= 1'b0;
          state       <= S_DECODE;
        end

        S_DECODE: begin
          state <= S_IDLE;
          if (is_tag) begin
            if (chan_ok) begin
              out_valid   <= 1'b1;
              out_channel <= read_data[27:24];
              out_time    <= {epoch, read_data[15:0], read_data[16 +: SUBTIME_BITS]};
              if (tag_flags) begin
                out_error <= 1'b1;
              end
            end else begin
              out_error <= 1'b1;
            end
          end else if (!is_nop) begin
            if (read_data[31]) begin
              epoch <= epoch + ROLLOVER_BITS'(1);
            end
            if (read_data[30]) begin
              out_overflow <= 1'b1;
            end
            if (nontag_junk) begin
              out_error <= 1'b1;
            end
          end
        end

        default: begin
          read_enable <= 1'b0;
          state       <= S_IDLE;
        end
      endcase

      if (clear) begin
        epoch        <= '0;
        out_overflow <= 1'b0;
        out_error    <= 1'b0;
      end
    end
  end

`ifdef TAGGER_DECODER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nop_count <= 32'd0;
      tag_count <= 32'd0;
    end else if (clear) begin
      nop_count <= 32'd0;
      tag_count <= 32'd0;
    end else begin
      if (decode_now && is_nop && (nop_count != 32'hFFFF_FFFF)) begin
        nop_count <= nop_count + 32'd1;
      end
      if (emit_tag && (tag_count != 32'hFFFF_FFFF)) begin
        tag_count <= tag_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tagger_word_decoder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tagger_word_decoder.
// A bench-side FIFO feeds the DUT; a word-level model applies each popped
// word one edge after the pop (when the DUT decodes it) and keeps a queue of
// expected timestamps. A negedge process compares all outputs every cycle.
// Directed scenarios pin the model with hand-computed literals, then a
// randomized phase exercises backpressure and clear.
// Configuration: CHANNELS=4, SUBTIME_BITS=6, ROLLOVER_BITS=4 (out_time 26 bits).
// -----------------------------------------------------------------------------
module tb_tagger_word_decoder;

  localparam int CH = 4;
  localparam int ST = 6;
  localparam int RB = 4;
  localparam int TW = RB + 16 + ST;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          read_empty = 1'b1;
  logic          read_enable;
  logic [31:0]   read_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_channel;
  logic [TW-1:0] out_time;
  logic          out_overflow;
  logic          out_error;
`ifdef TAGGER_DECODER_STATS_EN
  logic [31:0]   nop_count;
  logic [31:0]   tag_count;
`endif

  tagger_word_decoder #(
    .CHANNELS     (CH),
    .SUBTIME_BITS (ST),
    .ROLLOVER_BITS(RB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .read_empty  (read_empty),
    .read_enable (read_enable),
    .read_data   (read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_time    (out_time),
    .out_overflow(out_overflow),
    .out_error   (out_error)
`ifdef TAGGER_DECODER_STATS_EN
    ,
    .nop_count   (nop_count),
    .tag_count   (tag_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0]    ch;
    logic [TW-1:0] t;
  } tag_t;

  logic [31:0]       fifo_q[$];
  tag_t              exp_q[$];
  int unsigned       m_epoch;
  bit                m_ovf;
  bit                m_err;
  longint unsigned   m_nops;
  longint unsigned   m_tags;
  bit                pend_valid;
  logic [31:0]       pend_word;

  function automatic void model_decode(input logic [31:0] w);
    int unsigned     ch;
    longint unsigned tv;
    tag_t            e;
    ch = w[27:24];
    if (w[29]) begin
      if (ch < CH) begin
        // Absolute time = epoch * 2^(16+ST) + counter * 2^ST + (subtime mod 2^ST)
        tv = m_epoch;
        tv = tv * (64'd1 << (16 + ST));
        tv = tv + longint'(w[15:0]) * (64'd1 << ST);
        tv = tv + (longint'(w[23:16]) % (64'd1 << ST));
        e.ch = w[27:24];
        e.t  = tv[TW-1:0];
        exp_q.push_back(e);
        if (w[31] || w[30]) m_err = 1'b1;
        if (m_tags < 64'hFFFF_FFFF) m_tags = m_tags + 1;
      end else begin
        m_err = 1'b1;
      end
    end else if (w == 32'd0) begin
      if (m_nops < 64'hFFFF_FFFF) m_nops = m_nops + 1;
    end else begin
      if (w[31]) m_epoch = (m_epoch + 1) % (1 << RB);
      if (w[30]) m_ovf = 1'b1;
      if (w[28:0] != 29'd0) m_err = 1'b1;
    end
  endfunction

  // FIFO and model advance on the clock edge; model decodes the word the
  // edge after it was popped, then clear overrides, then the next pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_epoch    = 0;
      m_ovf      = 1'b0;
      m_err      = 1'b0;
      m_nops     = 0;
      m_tags     = 0;
      pend_valid = 1'b0;
      exp_q.delete();
      read_empty <= 1'b1;
      read_data  <= 32'd0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      if (pend_valid) begin
        model_decode(pend_word);
        pend_valid = 1'b0;
      end
      if (clear) begin
        m_epoch = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_nops  = 0;
        m_tags  = 0;
      end
      if (read_enable) begin
        check("fifo_underflow", 64'(read_empty), 64'd0);
        if (fifo_q.size() != 0) begin
          pend_word  = fifo_q.pop_front();
          pend_valid = 1'b1;
          read_data <= pend_word;
        end
      end
      read_empty <= (fifo_q.size() == 0);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_channel", 64'(out_channel), 64'(exp_q[0].ch));
        check("out_time", 64'(out_time), 64'(exp_q[0].t));
      end
      check("out_overflow", 64'(out_overflow), 64'(m_ovf));
      check("out_error", 64'(out_error), 64'(m_err));
`ifdef TAGGER_DECODER_STATS_EN
      check("nop_count", 64'(nop_count), m_nops);
      check("tag_count", 64'(tag_count), m_tags);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_budget", 64'(done), 64'd1);
    idle(8);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [1:0]  flags;
    logic [3:0]  ch;
    int          kind;
    r    = $urandom;
    kind = $urandom_range(0, 5);
    case (kind)
      0: return 32'd0;
      1: return {r[31:30], 30'd0};
      2: return {3'b000, r[28:1], 1'b1};
      default: begin
        flags = ($urandom_range(0, 7) == 0) ? r[31:30] : 2'b00;
        ch    = (kind == 5) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, CH - 1));
        return {flags, 2'b10, ch, r[23:0]};
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit         ok;
    int         cnt;
    logic [3:0] got[$];

    // Reset state
    idle(3);
    check("rst_read_enable", 64'(read_enable), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_channel", 64'(out_channel), 64'd0);
    check("rst_out_time", 64'(out_time), 64'd0);
    check("rst_out_overflow", 64'(out_overflow), 64'd0);
    check("rst_out_error", 64'(out_error), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: single tag, channel 2, subtime 0x56 truncated to 6 bits -> 0x16
    push(32'h2256_1234);
    wait_valid(40, ok);
    check("t1_seen", 64'(ok), 64'd1);
    check("t1_model_time", (exp_q.size() != 0) ? 64'(exp_q[0].t) : 64'hDEAD, 64'h0048D16);
    check("t1_channel", 64'(out_channel), 64'd2);
    check("t1_time", 64'(out_time), 64'h0048D16);
    idle(4);

    // 2: rollover then tag -> epoch 1 applies to the tag
    push(32'h8000_0000);
    push(32'h2000_0010);
    wait_valid(40, ok);
    check("t2_seen", 64'(ok), 64'd1);
    check("t2_time", 64'(out_time), 64'h0400400);
    check("t2_epoch", 64'(out_time[TW-1 -: RB]), 64'd1);
    idle(4);

    // 3: five NOPs -> nothing out, no error
    pulse_clear();
    repeat (5) push(32'h0000_0000);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("t3_no_valid", 64'(cnt), 64'd0);
    check("t3_no_error", 64'(out_error), 64'd0);
`ifdef TAGGER_DECODER_STATS_EN
    check("t3_nop_count", 64'(nop_count), 64'd5);
`endif

    // 4: rollover+overflow in one word, then clear
    push(32'hC000_0000);
    idle(8);
    check("t4_overflow_set", 64'(out_overflow), 64'd1);
    push(32'h2000_0001);
    wait_valid(40, ok);
    check("t4_time_epoch1", 64'(out_time), 64'h0400040);
    pulse_clear();
    check("t4_overflow_clr", 64'(out_overflow), 64'd0);
    push(32'h2000_0001);
    wait_valid(40, ok);
    check("t4_time_epoch0", 64'(out_time), 64'h0000040);
    idle(4);

    // 5: backpressure holds the first output and stops fetching
    out_ready = 1'b0;
    push(32'h2100_0001);
    push(32'h2200_0002);
    push(32'h2300_0003);
    wait_valid(40, ok);
    check("t5_first_seen", 64'(ok), 64'd1);
    got.delete();
    got.push_back(out_channel);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_enable) cnt++;
    end
    check("t5_no_fetch", 64'(cnt), 64'd0);
    check("t5_held_valid", 64'(out_valid), 64'd1);
    check("t5_held_channel", 64'(out_channel), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_channel);
    end
    check("t5_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      check("t5_order", 64'(got[i]), 64'(i + 1));
    end
    idle(4);

    // 6: 16 rollovers wrap a 4-bit epoch; out-of-range channel is dropped
    pulse_clear();
    repeat (16) push(32'h8000_0000);
    push(32'h2000_0000);
    wait_valid(120, ok);
    check("t6_seen", 64'(ok), 64'd1);
    check("t6_epoch_wrap", 64'(out_time[TW-1 -: RB]), 64'd0);
    check("t6_time", 64'(out_time), 64'd0);
    idle(2);
    push(32'h2500_0000);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("t6_dropped", 64'(cnt), 64'd0);
    check("t6_error", 64'(out_error), 64'd1);

    // Randomized traffic with backpressure and occasional clear
    pulse_clear();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 99) == 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) begin
        push(rand_word());
      end
    end
    drain();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
